mdu_ctrl: RTL and testbench

Multiply/divide unit sequencer for the P6 pipeline. Sits in the E stage, consumes the 4-bit MDU operation code produced by the instruction decoder, runs multi-cycle mult/div operations against private HI/LO registers, serves mthi/mtlo/mfhi/mflo, and raises the D-stage stall request while the unit is occupied.

---
 rtl/mdu_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide unit sequencer with private HI/LO registers
//
// Purpose: E-stage MDU sequencer. Accepts a 4-bit op code and runs multi-cycle
// mult/multu/div/divu/fdiv operations. It also serves mthi/mtlo/mfhi/mflo and
// raises the D-stage stall request while an operation is in flight.
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   mdu_op     in   4-bit op code (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                   5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 fdiv, 10-15 none)
//   op_valid   in   E-stage instruction is real
//   src_a      in   forwarded rs value
//   src_b      in   forwarded rt value
//   d_mdu_use  in   D-stage instruction uses the MDU
//   start      out  a multi-cycle op is accepted this cycle
//   busy       out  an operation is in progress
//   stall_req  out  stall request for the D stage
//   rd_data    out  hi for mfhi, lo for mflo, otherwise 0
//   hi, lo     out  architectural HI/LO
//   err_issue  out  sticky: a valid op arrived while busy
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  mdu_op,
   input  logic        op_valid,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        d_mdu_use,
   output logic        start,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] rd_data,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        err_issue
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

   localparam logic [CW-1:0] C_MULT = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] C_DIV  = CW'(DIV_CYCLES);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [31:0]   r_hi, w_hi_nxt;
   logic [31:0]   r_lo, w_lo_nxt;
   logic [31:0]   r_res_hi, w_res_hi_nxt;
   logic [31:0]   r_res_lo, w_res_lo_nxt;
   logic          r_res_wr, w_res_wr_nxt;
   logic          r_err, w_err_nxt;

   logic          w_is_start_op;
   logic          w_is_any_op;
   logic          w_start;

   logic [63:0]   w_prod_s;
   logic [63:0]   w_prod_u;
   logic [31:0]   w_div_b;
   logic [31:0]   w_uq;
   logic [31:0]   w_ur;
   logic [31:0]   w_abs_a;
   logic [31:0]   w_abs_b;
   logic [31:0]   w_abs_bg;
   logic [31:0]   w_sq_mag;
   logic [31:0]   w_sr_mag;
   logic [31:0]   w_sq;
   logic [31:0]   w_sr;

   assign w_is_start_op = (mdu_op == 4'd1) || (mdu_op == 4'd2) || (mdu_op == 4'd3) ||
                          (mdu_op == 4'd4) || (mdu_op == 4'd9);
   assign w_is_any_op   = (mdu_op >= 4'd1) && (mdu_op <= 4'd9);
   assign w_start       = op_valid && w_is_start_op && (r_state == IDLE);

   // Sign-extending to 64 bits lets one unsigned multiplier produce the signed product.
   assign w_prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
   assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};

   // Divisor forced to 1 when zero so the divider never sees 0; the result is discarded.
   assign w_div_b = (src_b == 32'd0) ? 32'd1 : src_b;
   assign w_uq    = src_a / w_div_b;
   assign w_ur    = src_a % w_div_b;

   // Signed divide via magnitudes. 0x80000000 / -1 yields magnitude 0x80000000,
   // whose negation is itself, giving the wrapped quotient with no special case.
   assign w_abs_a  = src_a[31] ? (32'd0 - src_a) : src_a;
   assign w_abs_b  = src_b[31] ? (32'd0 - src_b) : src_b;
   assign w_abs_bg = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
   assign w_sq_mag = w_abs_a / w_abs_bg;
   assign w_sr_mag = w_abs_a % w_abs_bg;
   assign w_sq     = (src_a[31] ^ src_b[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
   assign w_sr     = src_a[31] ? (32'd0 - w_sr_mag) : w_sr_mag;

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_hi_nxt     = r_hi;
      w_lo_nxt     = r_lo;
      w_res_hi_nxt = r_res_hi;
      w_res_lo_nxt = r_res_lo;
      w_res_wr_nxt = r_res_wr;
      w_err_nxt    = r_err;

      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_state_nxt  = RUN;
               w_res_wr_nxt = 1'b1;
               w_cnt_nxt    = C_DIV;
               case (mdu_op)
                  4'd1: begin
                     w_res_hi_nxt = w_prod_s[63:32];
                     w_res_lo_nxt = w_prod_s[31:0];
                     w_cnt_nxt    = C_MULT;
                  end
                  4'd2: begin
                     w_res_hi_nxt = w_prod_u[63:32];
                     w_res_lo_nxt = w_prod_u[31:0];
                     w_cnt_nxt    = C_MULT;
                  end
                  4'd3: begin
                     w_res_hi_nxt = w_sr;
                     w_res_lo_nxt = w_sq;
                  end
                  4'd4: begin
                     w_res_hi_nxt = w_ur;
                     w_res_lo_nxt = w_uq;
                  end
                  default: begin
                     w_res_hi_nxt = w_uq;
                     w_res_lo_nxt = w_ur;
                  end
               endcase
               if ((mdu_op != 4'd1) && (mdu_op != 4'd2) && (src_b == 32'd0)) begin
                  w_res_wr_nxt = 1'b0;
               end
            end else if (op_valid && (mdu_op == 4'd7)) begin
               w_hi_nxt = src_a;
            end else if (op_valid && (mdu_op == 4'd8)) begin
               w_lo_nxt = src_a;
            end
         end
         RUN: begin
            if (op_valid && w_is_any_op) begin
               w_err_nxt = 1'b1;
            end
            w_cnt_nxt = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               if (r_res_wr) begin
                  w_hi_nxt = r_res_hi;
                  w_lo_nxt = r_res_lo;
               end
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_res_hi <= '0;
         r_res_lo <= '0;
         r_res_wr <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_hi     <= w_hi_nxt;
         r_lo     <= w_lo_nxt;
         r_res_hi <= w_res_hi_nxt;
         r_res_lo <= w_res_lo_nxt;
         r_res_wr <= w_res_wr_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign start     = w_start;
   assign busy      = (r_state == RUN);
   assign stall_req = d_mdu_use && (w_start || (r_state == RUN));
   assign rd_data   = (mdu_op == 4'd5) ? r_hi :
                      (mdu_op == 4'd6) ? r_lo : 32'd0;
   assign hi        = r_hi;
   assign lo        = r_lo;
   assign err_issue = r_err;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl with a behavioural model
module tb_mdu_ctrl;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  mdu_op = 4'd0;
   logic        op_valid = 1'b0;
   logic [31:0] src_a = 32'd0;
   logic [31:0] src_b = 32'd0;
   logic        d_mdu_use = 1'b0;
   logic        start;
   logic        busy;
   logic        stall_req;
   logic [31:0] rd_data;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        err_issue;

   int checks = 0;
   int failures = 0;

   // Reference model: architectural HI/LO, pending result and remaining busy cycles.
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   logic        m_pwr, m_err;
   int          m_left;

   // Per-cycle captures of combinational outputs and their expected values.
   logic        o_start, o_stall, e_start, e_stall;
   logic [31:0] o_rd, e_rd;

   mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .mdu_op    (mdu_op),
      .op_valid  (op_valid),
      .src_a     (src_a),
      .src_b     (src_b),
      .d_mdu_use (d_mdu_use),
      .start     (start),
      .busy      (busy),
      .stall_req (stall_req),
      .rd_data   (rd_data),
      .hi        (hi),
      .lo        (lo),
      .err_issue (err_issue)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   function automatic logic is_start_op(input logic [3:0] op);
      return (op == 4'd1) || (op == 4'd2) || (op == 4'd3) || (op == 4'd4) || (op == 4'd9);
   endfunction

   task automatic model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] rh, output logic [31:0] rl, output logic wr);
      longint sa, sb, p, q, r;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      wr = 1'b1;
      rh = 32'd0;
      rl = 32'd0;
      case (op)
         4'd1: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
         4'd2: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
         4'd3: begin
            if (b == 32'd0) wr = 1'b0;
            else begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
         end
         4'd4: begin
            if (b == 32'd0) wr = 1'b0;
            else begin rl = a / b; rh = a % b; end
         end
         default: begin
            if (b == 32'd0) wr = 1'b0;
            else begin rh = a / b; rl = a % b; end
         end
      endcase
   endtask

   task automatic model_reset();
      m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0;
      m_pwr = 1'b0; m_err = 1'b0; m_left = 0;
   endtask

   // One clock cycle: apply inputs, capture combinational outputs, clock, advance model.
   task automatic cyc(input logic [3:0] op, input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic use_d);
      mdu_op = op; op_valid = v; src_a = a; src_b = b; d_mdu_use = use_d;
      #1;
      o_start = start;
      o_stall = stall_req;
      o_rd    = rd_data;
      e_start = v && is_start_op(op) && (m_left == 0);
      e_stall = use_d && (e_start || (m_left > 0));
      e_rd    = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
      @(posedge clk);
      #1;
      if (m_left > 0) begin
         if (v && (op >= 4'd1) && (op <= 4'd9)) m_err = 1'b1;
         m_left--;
         if ((m_left == 0) && m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
      end else if (v) begin
         if (is_start_op(op)) begin
            model_result(op, a, b, m_phi, m_plo, m_pwr);
            m_left = ((op == 4'd1) || (op == 4'd2)) ? MC : DC;
         end else if (op == 4'd7) begin
            m_hi = a;
         end else if (op == 4'd8) begin
            m_lo = a;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      model_reset();
      #3;
      checks++;
      if ({busy, err_issue, start, stall_req} !== 4'b0000 || hi !== 32'd0 || lo !== 32'd0 || rd_data !== 32'd0) begin
         failures++;
         $display("FAIL reset: busy=%0b err=%0b start=%0b stall=%0b hi=%h lo=%h rd=%h required all zero",
                  busy, err_issue, start, stall_req, hi, lo, rd_data);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_mult();
      cyc(4'd1, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
      checks++;
      if (o_start !== 1'b1) begin failures++; $display("FAIL mult_start: got %0b required 1", o_start); end
      for (int i = 1; i <= MC; i++) begin
         checks++;
         if (busy !== 1'b1) begin failures++; $display("FAIL mult_busy T+%0d: got %0b required 1", i, busy); end
         cyc(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      end
      checks++;
      if (busy !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
         failures++;
         $display("FAIL mult_result: busy=%0b hi=%h lo=%h required 0 ffffffff fffffffe", busy, hi, lo);
      end
   endtask

   task automatic test_back_to_back();
      cyc(4'd2, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
      checks++;
      if (o_start !== 1'b1) begin failures++; $display("FAIL b2b_start: got %0b required 1", o_start); end
      idle(MC);
      checks++;
      if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
         failures++;
         $display("FAIL multu_result: hi=%h lo=%h required 00000001 fffffffe", hi, lo);
      end
   endtask

   task automatic test_div();
      cyc(4'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
      idle(DC);
      checks++;
      if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
         failures++; $display("FAIL div_neg: hi=%h lo=%h required ffffffff fffffffd", hi, lo);
      end
      cyc(4'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      idle(DC);
      checks++;
      if (lo !== 32'h8000_0000 || hi !== 32'h0000_0000) begin
         failures++; $display("FAIL div_ovf: hi=%h lo=%h required 00000000 80000000", hi, lo);
      end
      cyc(4'd4, 1'b1, 32'd7, 32'd2, 1'b0);
      idle(DC);
      checks++;
      if (lo !== 32'd3 || hi !== 32'd1) begin
         failures++; $display("FAIL divu: hi=%h lo=%h required 1 3", hi, lo);
      end
      cyc(4'd9, 1'b1, 32'd7, 32'd2, 1'b0);
      idle(DC);
      checks++;
      if (hi !== 32'd3 || lo !== 32'd1) begin
         failures++; $display("FAIL fdiv: hi=%h lo=%h required 3 1", hi, lo);
      end
   endtask

   task automatic test_div_zero();
      cyc(4'd7, 1'b1, 32'h1234_5678, 32'd0, 1'b0);
      cyc(4'd5, 1'b1, 32'd0, 32'd0, 1'b0);
      checks++;
      if (o_rd !== 32'h1234_5678) begin
         failures++; $display("FAIL mthi_mfhi: rd=%h required 12345678", o_rd);
      end
      cyc(4'd4, 1'b1, 32'hDEAD_BEEF, 32'd0, 1'b0);
      idle(DC - 1);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL divzero_busy_last: got %0b required 1", busy); end
      idle(1);
      checks++;
      if (busy !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'd1) begin
         failures++; $display("FAIL divzero_keep: busy=%0b hi=%h lo=%h required 0 12345678 1", busy, hi, lo);
      end
   endtask

   task automatic test_stall();
      cyc(4'd1, 1'b1, 32'd3, 32'd4, 1'b1);
      checks++;
      if (o_stall !== 1'b1) begin failures++; $display("FAIL stall_T: got %0b required 1", o_stall); end
      for (int i = 1; i <= MC; i++) begin
         cyc(4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
         checks++;
         if (o_stall !== 1'b1) begin failures++; $display("FAIL stall_T+%0d: got %0b required 1", i, o_stall); end
      end
      cyc(4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
      checks++;
      if (o_stall !== 1'b0 || lo !== 32'd12 || hi !== 32'd0) begin
         failures++; $display("FAIL stall_release: stall=%0b hi=%h lo=%h required 0 0 c", o_stall, hi, lo);
      end
      cyc(4'd7, 1'b0, 32'hCAFE_0000, 32'd0, 1'b0);
      cyc(4'd12, 1'b1, 32'hCAFE_0001, 32'd5, 1'b0);
      checks++;
      if (hi !== 32'd0 || lo !== 32'd12 || busy !== 1'b0 || o_start !== 1'b0) begin
         failures++; $display("FAIL noop: hi=%h lo=%h busy=%0b start=%0b required 0 c 0 0", hi, lo, busy, o_start);
      end
   endtask

   task automatic test_err();
      checks++;
      if (err_issue !== 1'b0) begin failures++; $display("FAIL err_initial: got %0b required 0", err_issue); end
      cyc(4'd4, 1'b1, 32'd100, 32'd7, 1'b0);
      idle(2);
      cyc(4'd1, 1'b1, 32'd9, 32'd9, 1'b0);
      checks++;
      if (o_start !== 1'b0 || err_issue !== 1'b1) begin
         failures++; $display("FAIL err_issue: start=%0b err=%0b required 0 1", o_start, err_issue);
      end
      idle(6);
      checks++;
      if (busy !== 1'b1 || lo !== 32'd12) begin
         failures++; $display("FAIL err_T+10: busy=%0b lo=%h required 1 c", busy, lo);
      end
      idle(1);
      checks++;
      if (busy !== 1'b0 || lo !== 32'd14 || hi !== 32'd2 || err_issue !== 1'b1) begin
         failures++; $display("FAIL err_result: busy=%0b hi=%h lo=%h err=%0b required 0 2 e 1", busy, hi, lo, err_issue);
      end
   endtask

   task automatic test_reset_mid();
      cyc(4'd4, 1'b1, 32'd1000, 32'd3, 1'b0);
      idle(3);
      reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || err_issue !== 1'b0) begin
         failures++; $display("FAIL reset_mid: busy=%0b hi=%h lo=%h err=%0b required 0 0 0 0", busy, hi, lo, err_issue);
      end
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      idle(DC + 2);
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         failures++; $display("FAIL reset_no_late_write: busy=%0b hi=%h lo=%h required 0 0 0", busy, hi, lo);
      end
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic        v, u;
      logic [31:0] a, b;
      for (int n = 0; n < 400; n++) begin
         op = 4'($urandom_range(0, 15));
         v  = ($urandom_range(0, 3) != 0);
         u  = 1'($urandom_range(0, 1));
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 15) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
         // Mostly idle while busy so operations usually complete undisturbed.
         if (m_left > 0 && $urandom_range(0, 7) != 0) v = 1'b0;
         cyc(op, v, a, b, u);
         checks++;
         if (o_start !== e_start || o_stall !== e_stall || o_rd !== e_rd) begin
            failures++;
            $display("FAIL rand_comb[%0d] op=%0d: start=%0b/%0b stall=%0b/%0b rd=%h/%h (got/required)",
                     n, op, o_start, e_start, o_stall, e_stall, o_rd, e_rd);
         end
         checks++;
         if (busy !== (m_left > 0) || hi !== m_hi || lo !== m_lo || err_issue !== m_err) begin
            failures++;
            $display("FAIL rand_state[%0d]: busy=%0b/%0b hi=%h/%h lo=%h/%h err=%0b/%0b (got/required)",
                     n, busy, (m_left > 0), hi, m_hi, lo, m_lo, err_issue, m_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_back_to_back();
      test_div();
      test_div_zero();
      test_stall();
      test_err();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
